breakout_ctrl: RTL and testbench

BREAKOUT_CTRL -- requirements
Module: breakout_ctrl

---
 rtl/breakout_ctrl.sv | 150 +++++++++++++++
 tb/tb_breakout_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/breakout_ctrl.sv
// Breakout game controller: game-flow FSM, score, ball and brick bookkeeping.
module breakout_ctrl #(
   parameter int unsigned NUM_BRICKS = 48,
   parameter int unsigned NUM_BALLS  = 3,
   parameter int unsigned WAIT_TICKS = 120
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  btn,
   input  logic        timer_tick,
   input  logic        hit,
   input  logic        miss,
   output logic        gra_still,
   output logic [1:0]  game_state,
   output logic [15:0] score_bcd,
   output logic [1:0]  balls_left,
   output logic [5:0]  bricks_left,
   output logic        win
);

   localparam int unsigned BTN_W    = 5;
   localparam int unsigned TIMER_W  = 8;
   localparam int unsigned SCORE_W  = 16;
   localparam int unsigned BALLS_W  = 2;
   localparam int unsigned BRICKS_W = 6;

   typedef enum logic [1:0] {
      NEWGAME = 2'b00,
      PLAY    = 2'b01,
      NEWBALL = 2'b10,
      OVER    = 2'b11
   } state_t;

   state_t               state;
   logic [BTN_W-1:0]     btn_q;
   logic                 hit_q;
   logic                 miss_q;
   logic                 armed;
   logic [TIMER_W-1:0]   timer;
   logic                 hit_ev;
   logic                 miss_ev;
   logic                 start_ev;
   logic                 last_brick;
   logic [SCORE_W-1:0]   score_inc;
   logic                 carry;

   // Event detection; armed blocks a button held across reset release.
   assign hit_ev     = hit & ~hit_q;
   assign miss_ev    = miss & ~miss_q;
   assign start_ev   = armed & (btn_q == '0) & (btn != '0);
   assign last_brick = (bricks_left == BRICKS_W'(1));
   assign game_state = state;

   // Saturating four-digit BCD increment of the score.
   always_comb begin
      score_inc = score_bcd;
      carry     = (score_bcd != 16'h9999);
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (score_bcd[4*i +: 4] == 4'd9) begin
               score_inc[4*i +: 4] = 4'd0;
            end else begin
               score_inc[4*i +: 4] = score_bcd[4*i +: 4] + 4'd1;
               carry               = 1'b0;
            end
         end
      end
   end

   // Game FSM with registered outputs, edge registers and pause timer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= NEWGAME;
         gra_still   <= 1'b1;
         score_bcd   <= '0;
         balls_left  <= BALLS_W'(NUM_BALLS);
         bricks_left <= BRICKS_W'(NUM_BRICKS);
         win         <= 1'b0;
         timer       <= '0;
         btn_q       <= '0;
         hit_q       <= 1'b0;
         miss_q      <= 1'b0;
         armed       <= 1'b0;
      end else begin
         btn_q  <= btn;
         hit_q  <= hit;
         miss_q <= miss;
         armed  <= armed | (btn == '0);

         if (timer_tick && (timer != '0)) begin
            timer <= timer - TIMER_W'(1);
         end

         case (state)
            NEWGAME: begin
               if (start_ev) begin
                  state       <= PLAY;
                  gra_still   <= 1'b0;
                  score_bcd   <= '0;
                  balls_left  <= BALLS_W'(NUM_BALLS);
                  bricks_left <= BRICKS_W'(NUM_BRICKS);
                  win         <= 1'b0;
               end
            end
            PLAY: begin
               if (hit_ev) begin
                  score_bcd <= score_inc;
                  if (bricks_left != '0) begin
                     bricks_left <= bricks_left - BRICKS_W'(1);
                  end
               end
               // A clearing hit wins and masks a simultaneous miss.
               if (hit_ev && last_brick) begin
                  win       <= 1'b1;
                  timer     <= TIMER_W'(WAIT_TICKS);
                  state     <= OVER;
                  gra_still <= 1'b1;
               end else if (miss_ev) begin
                  timer     <= TIMER_W'(WAIT_TICKS);
                  gra_still <= 1'b1;
                  if (balls_left <= BALLS_W'(1)) begin
                     balls_left <= '0;
                     win        <= 1'b0;
                     state      <= OVER;
                  end else begin
                     balls_left <= balls_left - BALLS_W'(1);
                     state      <= NEWBALL;
                  end
               end
            end
            NEWBALL: begin
               if (timer == '0) begin
                  state     <= PLAY;
                  gra_still <= 1'b0;
               end
            end
            OVER: begin
               if (timer == '0) begin
                  state <= NEWGAME;
               end
            end
            default: begin
               state     <= NEWGAME;
               gra_still <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_breakout_ctrl.sv
// Self-checking bench for breakout_ctrl: directed scenarios plus random play
// against a behavioural model, on a default and a two-brick instance.
module tb_breakout_ctrl;

   localparam int NI = 2;
   localparam int S_NEWGAME = 0;
   localparam int S_PLAY    = 1;
   localparam int S_NEWBALL = 2;
   localparam int S_OVER    = 3;

   logic       clk        = 1'b0;
   logic       reset      = 1'b1;
   logic [4:0] btn        = 5'h10;
   logic       timer_tick = 1'b0;
   logic       hit        = 1'b0;
   logic       miss       = 1'b0;

   logic        gs0_still, gs1_still, win0, win1;
   logic [1:0]  gs0, gs1, balls0, balls1;
   logic [15:0] score0, score1;
   logic [5:0]  bricks0, bricks1;

   int n_vec  = 0;
   int n_miss = 0;
   bit cmp_en = 1'b0;

   // Model state, one entry per instance
   int m_state[NI], m_score[NI], m_balls[NI], m_bricks[NI], m_timer[NI];
   bit m_win[NI];
   logic [4:0] m_btn_prev;
   bit m_hit_prev, m_miss_prev, m_armed;
   bit hev, mev, sev;

   breakout_ctrl dut (
      .clk(clk), .reset(reset), .btn(btn), .timer_tick(timer_tick),
      .hit(hit), .miss(miss), .gra_still(gs0_still), .game_state(gs0),
      .score_bcd(score0), .balls_left(balls0), .bricks_left(bricks0), .win(win0)
   );

   breakout_ctrl #(.NUM_BRICKS(2), .NUM_BALLS(3), .WAIT_TICKS(3)) dut_small (
      .clk(clk), .reset(reset), .btn(btn), .timer_tick(timer_tick),
      .hit(hit), .miss(miss), .gra_still(gs1_still), .game_state(gs1),
      .score_bcd(score1), .balls_left(balls1), .bricks_left(bricks1), .win(win1)
   );

   always #5 clk = ~clk;

   function automatic int cfg_bricks(input int k);
      return (k == 0) ? 48 : 2;
   endfunction

   function automatic int cfg_balls(input int k);
      return (k == 0) ? 3 : 3;
   endfunction

   function automatic int cfg_wait(input int k);
      return (k == 0) ? 120 : 3;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic chk(input string name, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s inst%0d at %0t: got %0h expected %0h", name, k, $time, act, exp);
      end
   endtask

   task automatic model_reset(input int k);
      m_state[k]  = S_NEWGAME;
      m_score[k]  = 0;
      m_balls[k]  = cfg_balls(k);
      m_bricks[k] = cfg_bricks(k);
      m_timer[k]  = 0;
      m_win[k]    = 1'b0;
   endtask

   // One clock of game rules for instance k, using pre-edge values
   task automatic model_step(input int k);
      int  old_timer;
      bit  load, ended;
      old_timer = m_timer[k];
      load      = 1'b0;
      ended     = 1'b0;
      case (m_state[k])
         S_NEWGAME: if (sev) begin
            m_state[k]  = S_PLAY;
            m_score[k]  = 0;
            m_balls[k]  = cfg_balls(k);
            m_bricks[k] = cfg_bricks(k);
            m_win[k]    = 1'b0;
         end
         S_PLAY: begin
            if (hev) begin
               if (m_score[k] < 9999) m_score[k] = m_score[k] + 1;
               if (m_bricks[k] > 0) begin
                  m_bricks[k] = m_bricks[k] - 1;
                  if (m_bricks[k] == 0) begin
                     m_win[k]   = 1'b1;
                     m_state[k] = S_OVER;
                     load       = 1'b1;
                     ended      = 1'b1;
                  end
               end
            end
            if (mev && !ended) begin
               load = 1'b1;
               if (m_balls[k] == 1) begin
                  m_balls[k] = 0;
                  m_win[k]   = 1'b0;
                  m_state[k] = S_OVER;
               end else begin
                  m_balls[k] = m_balls[k] - 1;
                  m_state[k] = S_NEWBALL;
               end
            end
         end
         S_NEWBALL: if (old_timer == 0) m_state[k] = S_PLAY;
         default:   if (old_timer == 0) m_state[k] = S_NEWGAME;
      endcase
      if (load) m_timer[k] = cfg_wait(k);
      else if (timer_tick && old_timer > 0) m_timer[k] = old_timer - 1;
   endtask

   // Reference model clocking
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NI; k++) model_reset(k);
         m_btn_prev  = 5'h0;
         m_hit_prev  = 1'b0;
         m_miss_prev = 1'b0;
         m_armed     = 1'b0;
      end else begin
         hev = hit && !m_hit_prev;
         mev = miss && !m_miss_prev;
         sev = m_armed && (m_btn_prev == 5'h0) && (btn != 5'h0);
         for (int k = 0; k < NI; k++) model_step(k);
         m_btn_prev  = btn;
         m_hit_prev  = hit;
         m_miss_prev = miss;
         if (btn == 5'h0) m_armed = 1'b1;
      end
   end

   task automatic cmp_inst(input int k, input logic [1:0] gs, input logic st,
                           input logic [15:0] sc, input logic [1:0] bl,
                           input logic [5:0] bk, input logic w);
      chk("game_state", k, 32'(gs), 32'(m_state[k]));
      chk("gra_still", k, 32'(st), 32'(m_state[k] != S_PLAY));
      chk("score_bcd", k, 32'(sc), 32'(to_bcd(m_score[k])));
      chk("balls_left", k, 32'(bl), 32'(m_balls[k]));
      chk("bricks_left", k, 32'(bk), 32'(m_bricks[k]));
      chk("win", k, 32'(w), 32'(m_win[k]));
   endtask

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (cmp_en) begin
         cmp_inst(0, gs0, gs0_still, score0, balls0, bricks0, win0);
         cmp_inst(1, gs1, gs1_still, score1, balls1, bricks1, win1);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         timer_tick = 1'b1;
         step(1);
         timer_tick = 1'b0;
         step(1);
      end
   endtask

   task automatic pulse_miss();
      miss = 1'b1;
      step(1);
      miss = 1'b0;
   endtask

   initial begin
      // Button held through reset release must not start a game
      step(1);
      cmp_en = 1'b1;
      step(2);
      reset = 1'b0;
      step(3);
      chk("held_btn_no_start", 0, 32'(gs0), 32'd0);
      btn = 5'h0;
      step(2);
      chk("rst_state", 0, 32'(gs0), 32'd0);
      chk("rst_still", 0, 32'(gs0_still), 32'd1);
      chk("rst_balls", 0, 32'(balls0), 32'd3);
      chk("rst_bricks", 0, 32'(bricks0), 32'd48);
      chk("rst_score", 0, 32'(score0), 32'd0);

      // Start game
      btn = 5'h10;
      step(1);
      btn = 5'h0;
      chk("start_state", 0, 32'(gs0), 32'd1);
      chk("start_still", 0, 32'(gs0_still), 32'd0);
      chk("start_balls", 0, 32'(balls0), 32'd3);
      chk("start_bricks", 0, 32'(bricks0), 32'd48);

      // Long hit levels count once each
      for (int i = 0; i < 10; i++) begin
         hit = 1'b1;
         step(5);
         hit = 1'b0;
         step(2);
      end
      chk("ten_hits_score", 0, 32'(score0), 32'h0010);
      chk("ten_hits_bricks", 0, 32'(bricks0), 32'd38);

      // Lose first ball, pause, resume
      pulse_miss();
      chk("miss1_state", 0, 32'(gs0), 32'd2);
      chk("miss1_balls", 0, 32'(balls0), 32'd2);
      chk("miss1_still", 0, 32'(gs0_still), 32'd1);
      ticks(119);
      chk("pause_119", 0, 32'(gs0), 32'd2);
      ticks(1);
      chk("pause_done", 0, 32'(gs0), 32'd1);

      // Second and last balls
      pulse_miss();
      ticks(120);
      step(1);
      chk("miss2_balls", 0, 32'(balls0), 32'd1);
      pulse_miss();
      chk("last_ball_state", 0, 32'(gs0), 32'd3);
      chk("last_ball_win", 0, 32'(win0), 32'd0);
      ticks(120);
      step(1);
      chk("over_done_state", 0, 32'(gs0), 32'd0);
      chk("over_score_kept", 0, 32'(score0), 32'h0010);

      // Two-brick game: clearing hit coincident with miss wins
      btn = 5'h01;
      step(1);
      btn = 5'h0;
      hit = 1'b1;
      step(1);
      hit = 1'b0;
      step(2);
      hit  = 1'b1;
      miss = 1'b1;
      step(1);
      hit  = 1'b0;
      miss = 1'b0;
      chk("small_win_state", 1, 32'(gs1), 32'd3);
      chk("small_win", 1, 32'(win1), 32'd1);
      chk("small_win_balls", 1, 32'(balls1), 32'd3);
      chk("big_hitmiss_state", 0, 32'(gs0), 32'd2);

      // Asynchronous reset mid-pause
      ticks(60);
      #3 reset = 1'b1;
      #1;
      chk("async_rst_state", 0, 32'(gs0), 32'd0);
      chk("async_rst_score", 0, 32'(score0), 32'd0);
      step(2);
      reset = 1'b0;
      step(2);

      // Random play
      for (int c = 0; c < 5000; c++) begin
         if (reset) reset = 1'b0;
         else if ($urandom_range(0, 1499) == 0) reset = 1'b1;
         if ($urandom_range(0, 3) == 0) hit = ~hit;
         if ($urandom_range(0, 15) == 0) miss = ~miss;
         timer_tick = ($urandom_range(0, 1) == 0);
         btn = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(1, 31)) : 5'h0;
         step(1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
